// File: rtl/trace_checker_pkg.sv
// Shared types and constants for the byte-serial CPU trace-line checker.
// Holds the parser state encoding, error-bit positions, format codes and ASCII literals.
package trace_checker_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TIME,
        ST_PC,
        ST_COLON_SP,
        ST_DEST_PFX,
        ST_REG,
        ST_ADDR,
        ST_PRE_LT,
        ST_EQ,
        ST_PRE_DATA,
        ST_DATA
    } state_t;

    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_REG  = 3;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_LA     = 8'h61;
    localparam logic [7:0] CH_LF     = 8'h66;
    localparam logic [7:0] CH_UA     = 8'h41;
    localparam logic [7:0] CH_UF     = 8'h46;

    // Isolates the least-significant set bit (x & -x); zero for zero.
    function automatic logic [31:0] lowest_set(input logic [31:0] x);
        return x & (~x + 32'd1);
    endfunction

endpackage

// File: rtl/char_classify.sv
// Combinational ASCII digit classifier: decimal/hex flags and the digit's 4-bit value.
// Upper-case hex is accepted only when UPPER_HEX is non-zero.
module char_classify
    import trace_checker_pkg::*;
#(
    parameter int UPPER_HEX = 0
) (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nib
);

    logic is_lower;
    logic is_upper;

    always_comb begin
        is_dec   = (char >= CH_0) && (char <= CH_9);
        is_lower = (char >= CH_LA) && (char <= CH_LF);
        is_upper = (UPPER_HEX != 0) && (char >= CH_UA) && (char <= CH_UF);
        is_hex   = is_dec || is_lower || is_upper;
        nib      = 4'd0;
        if (is_dec) begin
            nib = char[3:0];
        end else if (is_lower || is_upper) begin
            // 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
            nib = 4'd9 + char[3:0];
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Byte-serial parser for register-write and memory-write CPU trace lines, with
// per-line field checks and saturating line/error statistics.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          REG_DIGITS  = 2,
    parameter int          NUM_REGS    = 32,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4FFF,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
    parameter int          UPPER_HEX   = 0,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic             line_valid,
    output logic [31:0]      pc_out,
    output logic [31:0]      dest_out,
    output logic [31:0]      data_out,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [7:0]  TIME_LIM = 8'(TIME_DIGITS);
    localparam logic [7:0]  REG_LIM  = 8'(REG_DIGITS);
    localparam logic [7:0]  HEX_LEN  = 8'd8;
    localparam logic [31:0] REG_LIM32 = 32'(NUM_REGS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [31:0] acc_dec(input logic [31:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + {28'd0, d};
    endfunction

    function automatic logic [31:0] acc_hex(input logic [31:0] x, input logic [3:0] d);
        return {x[27:0], d};
    endfunction

    logic        is_dec;
    logic        is_hex;
    logic [3:0]  nib;

    char_classify #(.UPPER_HEX(UPPER_HEX)) u_classify (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nib    (nib)
    );

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        is_mem;
    logic        mem_nxt;
    logic        restart;
    logic        ld_t, ld_p, ld_r, ld_a, ld_d;
    logic        accept;
    logic [31:0] t_acc, p_acc, dst_acc, d_acc;
    logic [15:0] half_freq;
    logic [3:0]  err_nxt;

    assign restart = (char == CH_CARET);

    // Next-state decode: one character per cycle, any misfit drops to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        cnt_nxt   = cnt;
        mem_nxt   = is_mem;
        ld_t      = 1'b0;
        ld_p      = 1'b0;
        ld_r      = 1'b0;
        ld_a      = 1'b0;
        ld_d      = 1'b0;
        accept    = 1'b0;
        if (restart) begin
            state_nxt = ST_TIME;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_TIME: begin
                    if (is_dec && cnt < TIME_LIM) begin
                        state_nxt = ST_TIME;
                        cnt_nxt   = cnt + 8'd1;
                        ld_t      = 1'b1;
                    end else if (char == CH_AT && cnt != 8'd0) begin
                        state_nxt = ST_PC;
                        cnt_nxt   = 8'd0;
                    end
                end
                ST_PC: begin
                    if (is_hex && cnt < HEX_LEN) begin
                        state_nxt = ST_PC;
                        cnt_nxt   = cnt + 8'd1;
                        ld_p      = 1'b1;
                    end else if (char == CH_COLON && cnt == HEX_LEN) begin
                        state_nxt = ST_COLON_SP;
                    end
                end
                ST_COLON_SP, ST_DEST_PFX: begin
                    if (char == CH_SPACE) begin
                        state_nxt = ST_DEST_PFX;
                    end else if (char == CH_DOLLAR) begin
                        state_nxt = ST_REG;
                        cnt_nxt   = 8'd0;
                        mem_nxt   = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_nxt = ST_ADDR;
                        cnt_nxt   = 8'd0;
                        mem_nxt   = 1'b1;
                    end
                end
                ST_REG: begin
                    if (is_dec && cnt < REG_LIM) begin
                        state_nxt = ST_REG;
                        cnt_nxt   = cnt + 8'd1;
                        ld_r      = 1'b1;
                    end else if (cnt != 8'd0 && char == CH_SPACE) begin
                        state_nxt = ST_PRE_LT;
                    end else if (cnt != 8'd0 && char == CH_LT) begin
                        state_nxt = ST_EQ;
                    end
                end
                ST_ADDR: begin
                    if (is_hex && cnt < HEX_LEN) begin
                        state_nxt = ST_ADDR;
                        cnt_nxt   = cnt + 8'd1;
                        ld_a      = 1'b1;
                    end else if (cnt == HEX_LEN && char == CH_SPACE) begin
                        state_nxt = ST_PRE_LT;
                    end else if (cnt == HEX_LEN && char == CH_LT) begin
                        state_nxt = ST_EQ;
                    end
                end
                ST_PRE_LT: begin
                    if (char == CH_SPACE) state_nxt = ST_PRE_LT;
                    else if (char == CH_LT) state_nxt = ST_EQ;
                end
                ST_EQ: begin
                    if (char == CH_EQ) state_nxt = ST_PRE_DATA;
                end
                ST_PRE_DATA: begin
                    if (char == CH_SPACE) begin
                        state_nxt = ST_PRE_DATA;
                    end else if (is_hex) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = 8'd1;
                        ld_d      = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (is_hex && cnt < HEX_LEN) begin
                        state_nxt = ST_DATA;
                        cnt_nxt   = cnt + 8'd1;
                        ld_d      = 1'b1;
                    end else if (char == CH_HASH && cnt == HEX_LEN) begin
                        accept = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Field checks, evaluated against the completed accumulators on the '#' cycle.
    always_comb begin
        half_freq         = freq >> 1;
        err_nxt           = 4'd0;
        err_nxt[ERR_TIME] = lowest_set(t_acc) < {16'd0, half_freq};
        err_nxt[ERR_PC]   = (p_acc < PC_LO) || (p_acc > PC_HI) || (p_acc[1:0] != 2'b00);
        if (is_mem) begin
            err_nxt[ERR_ADDR] = (dst_acc < ADDR_LO) || (dst_acc > ADDR_HI) ||
                                (dst_acc[1:0] != 2'b00);
        end else begin
            err_nxt[ERR_REG] = (dst_acc >= REG_LIM32);
        end
    end

    // Field accumulators: cleared by any '^', never need a reset of their own.
    always_ff @(posedge clk) begin
        if (restart) begin
            t_acc   <= 32'd0;
            p_acc   <= 32'd0;
            dst_acc <= 32'd0;
            d_acc   <= 32'd0;
        end else begin
            if (ld_t) t_acc <= acc_dec(t_acc, nib);
            if (ld_p) p_acc <= acc_hex(p_acc, nib);
            if (ld_r) dst_acc <= acc_dec(dst_acc, nib);
            if (ld_a) dst_acc <= acc_hex(dst_acc, nib);
            if (ld_d) d_acc <= acc_hex(d_acc, nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            is_mem      <= 1'b0;
            format_type <= FMT_NONE;
            error_code  <= 4'd0;
            line_valid  <= 1'b0;
            pc_out      <= 32'd0;
            dest_out    <= 32'd0;
            data_out    <= 32'd0;
            line_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            is_mem      <= mem_nxt;
            line_valid  <= accept;
            format_type <= accept ? (is_mem ? FMT_MEM : FMT_REG) : FMT_NONE;
            error_code  <= accept ? err_nxt : 4'd0;
            if (accept) begin
                pc_out   <= p_acc;
                dest_out <= dst_acc;
                data_out <= d_acc;
                line_cnt <= sat_inc(line_cnt);
                if (err_nxt != 4'd0) err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed trace lines plus randomized streams, checked
// against a string-level line parser that models the trace grammar directly.
module tb_trace_checker;

    localparam int          TIME_DIGITS = 4;
    localparam int          REG_DIGITS  = 2;
    localparam int          NUM_REGS    = 32;
    localparam logic [31:0] PC_LO       = 32'h0000_3000;
    localparam logic [31:0] PC_HI       = 32'h0000_4FFF;
    localparam logic [31:0] ADDR_LO     = 32'h0000_0000;
    localparam logic [31:0] ADDR_HI     = 32'h0000_2FFF;

    logic        clk;
    logic        reset;
    logic [7:0]  ch;
    logic [15:0] freq;

    logic [1:0]  fmt0, fmt1;
    logic [3:0]  err0, err1;
    logic        vld0, vld1;
    logic [31:0] pc0, pc1, dest0, dest1, data0, data1;
    logic [15:0] lc0, ec0;
    logic [3:0]  lc1, ec1;

    trace_checker dut0 (
        .clk(clk), .reset(reset), .char(ch), .freq(freq),
        .format_type(fmt0), .error_code(err0), .line_valid(vld0),
        .pc_out(pc0), .dest_out(dest0), .data_out(data0),
        .line_cnt(lc0), .err_cnt(ec0)
    );

    trace_checker #(.UPPER_HEX(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .char(ch), .freq(freq),
        .format_type(fmt1), .error_code(err1), .line_valid(vld1),
        .pc_out(pc1), .dest_out(dest1), .data_out(data1),
        .line_cnt(lc1), .err_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit rnd_freq = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state, one slot per DUT (slot 1 accepts upper-case hex, 4-bit counters).
    logic [1:0]  m_fmt[2];
    logic [3:0]  m_err[2];
    logic        m_vld[2];
    logic [31:0] m_pc[2], m_dest[2], m_data[2];
    int          m_lc[2], m_ec[2];
    string       buf_s[2];
    bit          open_s[2];
    int          cmax[2] = '{65535, 15};

    function automatic byte at(input string s, input int i);
        return (i < s.len()) ? s[i] : 8'h00;
    endfunction

    function automatic int hexval(input byte c, input bit up);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (up && c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    function automatic int take_dec(input string s, inout int i, output longint v);
        int n = 0;
        v = 0;
        while (at(s, i) >= "0" && at(s, i) <= "9") begin
            v = (v * 10 + (int'(s[i]) - 48)) & 64'hFFFF_FFFF;
            n++; i++;
        end
        return n;
    endfunction

    function automatic int take_hex(input string s, input bit up, inout int i, output longint v);
        int n = 0;
        v = 0;
        while (hexval(at(s, i), up) >= 0) begin
            v = (v * 16 + hexval(s[i], up)) & 64'hFFFF_FFFF;
            n++; i++;
        end
        return n;
    endfunction

    function automatic void skip_sp(input string s, inout int i);
        while (at(s, i) == " ") i++;
    endfunction

    // Whole-line match of the trace grammar; returns 1 and the fields when the line is legal.
    function automatic bit parse(input string s, input bit up, output bit mem,
                                 output longint t, output longint p,
                                 output longint dst, output longint d);
        int i = 1;
        int n;
        mem = 0; t = 0; p = 0; dst = 0; d = 0;
        if (at(s, 0) != "^") return 0;
        n = take_dec(s, i, t);
        if (n < 1 || n > TIME_DIGITS || at(s, i) != "@") return 0;
        i++;
        if (take_hex(s, up, i, p) != 8 || at(s, i) != ":") return 0;
        i++;
        skip_sp(s, i);
        if (at(s, i) == "$") begin
            i++;
            n = take_dec(s, i, dst);
            if (n < 1 || n > REG_DIGITS) return 0;
        end else if (at(s, i) == "*") begin
            i++;
            mem = 1;
            if (take_hex(s, up, i, dst) != 8) return 0;
        end else return 0;
        skip_sp(s, i);
        if (at(s, i) != "<" || at(s, i + 1) != "=") return 0;
        i += 2;
        skip_sp(s, i);
        if (take_hex(s, up, i, d) != 8 || at(s, i) != "#") return 0;
        return (i + 1 == s.len());
    endfunction

    task automatic model_step(input byte c, input bit rst);
        bit mem;
        longint t, p, dst, d;
        logic [31:0] tt, lsb;
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_fmt[k] = 0; m_err[k] = 0; m_vld[k] = 0;
                m_pc[k] = 0; m_dest[k] = 0; m_data[k] = 0;
                m_lc[k] = 0; m_ec[k] = 0; buf_s[k] = ""; open_s[k] = 0;
            end else begin
                m_vld[k] = 0; m_fmt[k] = 0; m_err[k] = 0;
                if (c == "^") begin
                    buf_s[k] = "^"; open_s[k] = 1;
                end else if (open_s[k]) begin
                    buf_s[k] = $sformatf("%s%c", buf_s[k], c);
                    if (c == "#") begin
                        open_s[k] = 0;
                        if (parse(buf_s[k], k == 1, mem, t, p, dst, d)) begin
                            tt = t[31:0];
                            lsb = 0;
                            for (int b = 0; b < 32; b++)
                                if (tt[b]) begin lsb = 32'd1 << b; break; end
                            e = 0;
                            e[0] = (lsb < 32'(freq / 2));
                            e[1] = (p < PC_LO) || (p > PC_HI) || (p % 4 != 0);
                            if (mem) e[2] = (dst < ADDR_LO) || (dst > ADDR_HI) || (dst % 4 != 0);
                            else     e[3] = (dst >= NUM_REGS);
                            m_vld[k] = 1; m_fmt[k] = mem ? 2 : 1; m_err[k] = e;
                            m_pc[k] = p[31:0]; m_dest[k] = dst[31:0]; m_data[k] = d[31:0];
                            if (m_lc[k] < cmax[k]) m_lc[k]++;
                            if (e != 0 && m_ec[k] < cmax[k]) m_ec[k]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cmp_dut(input int k, input logic [1:0] f, input logic [3:0] e, input logic v,
                           input logic [31:0] p, input logic [31:0] dd, input logic [31:0] da,
                           input logic [15:0] lc, input logic [15:0] ec);
        chk($sformatf("d%0d.line_valid", k), 64'(v), 64'(m_vld[k]));
        chk($sformatf("d%0d.format_type", k), 64'(f), 64'(m_fmt[k]));
        chk($sformatf("d%0d.error_code", k), 64'(e), 64'(m_err[k]));
        chk($sformatf("d%0d.pc_out", k), 64'(p), 64'(m_pc[k]));
        chk($sformatf("d%0d.dest_out", k), 64'(dd), 64'(m_dest[k]));
        chk($sformatf("d%0d.data_out", k), 64'(da), 64'(m_data[k]));
        chk($sformatf("d%0d.line_cnt", k), 64'(lc), 64'(m_lc[k]));
        chk($sformatf("d%0d.err_cnt", k), 64'(ec), 64'(m_ec[k]));
    endtask

    task automatic tick(input byte c, input bit rst);
        @(negedge clk);
        ch = c;
        reset = rst;
        if (rnd_freq) freq = 16'($urandom_range(0, 64));
        @(posedge clk);
        model_step(c, rst);
        #1;
        cmp_dut(0, fmt0, err0, vld0, pc0, dest0, data0, lc0, ec0);
        cmp_dut(1, fmt1, err1, vld1, pc1, dest1, data1, {12'd0, lc1}, {12'd0, ec1});
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) tick(s[i], 1'b0);
    endtask

    function automatic string hex8(input logic [31:0] v, input bit up);
        string h = $sformatf("%08x", v);
        return up ? h.toupper() : h;
    endfunction

    function automatic string spaces();
        string s = "";
        int n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] lo, input logic [31:0] hi);
        case ($urandom_range(0, 5))
            0, 1, 2: return lo + 32'($urandom_range(0, int'(hi - lo)));
            3:       return $urandom;
            4:       return lo - 32'd4;
            default: return hi + 32'd1;
        endcase
    endfunction

    function automatic string rand_line();
        string s = "^";
        string junk = " ^#@:$*<=0aAzx9";
        bit up = ($urandom_range(0, 3) == 0);
        int nt = $urandom_range(1, 5);
        int pos;
        for (int i = 0; i < nt; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        s = {s, "@", hex8(pick(PC_LO, PC_HI), up), ":", spaces()};
        if ($urandom_range(0, 1) == 1) s = {s, "*", hex8(pick(ADDR_LO, ADDR_HI), up)};
        else begin
            s = {s, "$"};
            nt = $urandom_range(1, 3);
            for (int i = 0; i < nt; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        end
        s = {s, spaces(), "<=", spaces(), hex8($urandom, up), "#"};
        if ($urandom_range(0, 5) == 0) begin
            pos = $urandom_range(1, s.len() - 1);
            s.putc(pos, junk[$urandom_range(0, junk.len() - 1)]);
        end
        return s;
    endfunction

    string s_mid;

    initial begin
        ch = 8'h00; reset = 1'b1; freq = 16'd0;
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        chk("rst.line_valid", 64'(vld0), 0);
        chk("rst.format_type", 64'(fmt0), 0);
        chk("rst.error_code", 64'(err0), 0);
        chk("rst.pc_out", 64'(pc0), 0);
        chk("rst.dest_out", 64'(dest0), 0);
        chk("rst.data_out", 64'(data0), 0);
        chk("rst.line_cnt", 64'(lc0), 0);
        chk("rst.err_cnt", 64'(ec0), 0);

        freq = 16'd2;
        send("^10@00003000: $5 <= 0000000a#");
        chk("reg.format_type", 64'(fmt0), 1);
        chk("reg.error_code", 64'(err0), 0);
        chk("reg.line_valid", 64'(vld0), 1);
        chk("reg.pc_out", 64'(pc0), 64'h3000);
        chk("reg.dest_out", 64'(dest0), 5);
        chk("reg.data_out", 64'(data0), 64'hA);
        chk("reg.line_cnt", 64'(lc0), 1);
        tick(" ", 1'b0);
        chk("pulse.line_valid", 64'(vld0), 0);
        chk("pulse.format_type", 64'(fmt0), 0);
        chk("hold.pc_out", 64'(pc0), 64'h3000);

        send("^8@00003004:*00000010<=12345678#");
        chk("mem.format_type", 64'(fmt0), 2);
        chk("mem.error_code", 64'(err0), 0);
        chk("mem.dest_out", 64'(dest0), 64'h10);
        chk("mem.data_out", 64'(data0), 64'h12345678);

        freq = 16'd32;
        send("^12@00003002: $40 <= 00000000#");
        chk("errs.format_type", 64'(fmt0), 1);
        chk("errs.error_code", 64'(err0), 64'b1011);
        chk("errs.err_cnt", 64'(ec0), 1);

        freq = 16'd2;
        send("^12@^3@00003000: *00003000 <= 00000000#");
        chk("restart.format_type", 64'(fmt0), 2);
        chk("restart.error_code", 64'(err0), 64'b0100);
        chk("restart.line_cnt", 64'(lc0), 4);

        send("^1@3000: $1 <= 00000000#");
        chk("short_pc.line_cnt", 64'(lc0), 4);
        send("^12345@00003000: $1 <= 00000000#");
        chk("long_time.line_cnt", 64'(lc0), 4);
        send("^1@00003000: $1 < = 00000000#");
        chk("lt_gap.line_cnt", 64'(lc0), 4);
        chk("lt_gap.err_cnt", 64'(ec0), 2);

        send("^4@0000300C: *0000ABCC <= FFFFFFFF#");
        chk("upper.pc_out", 64'(pc1), 64'h300C);
        chk("upper.error_code", 64'(err1), 64'b0100);
        chk("upper.line_valid", 64'(vld1), 1);
        chk("upper.line_cnt", 64'(lc1), 5);
        chk("upper_rej.line_valid", 64'(vld0), 0);

        send("^1@00003000:$0<=00000000#^2@00003008:$31<=ffffffff#");
        chk("b2b.line_cnt", 64'(lc0), 6);
        chk("b2b.dest_out", 64'(dest0), 31);

        s_mid = "^10@00003000: $5 <= 0000000a#";
        for (int i = 0; i < 5; i++) tick(s_mid[i], 1'b0);
        tick("0", 1'b1);
        for (int i = 5; i < s_mid.len(); i++) tick(s_mid[i], 1'b0);
        chk("midrst.line_cnt", 64'(lc0), 0);
        chk("midrst.err_cnt", 64'(ec0), 0);
        chk("midrst.line_valid", 64'(vld0), 0);
        send(s_mid);
        chk("after_rst.line_valid", 64'(vld0), 1);
        chk("after_rst.line_cnt", 64'(lc0), 1);

        for (int i = 0; i < s_mid.len() - 1; i++) tick(s_mid[i], 1'b0);
        tick("#", 1'b1);
        chk("rst_hash.line_valid", 64'(vld0), 0);
        chk("rst_hash.line_cnt", 64'(lc0), 0);
        tick(" ", 1'b0);

        rnd_freq = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) tick("x", 1'b0);
            end
            send(rand_line());
        end
        tick(" ", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/trace_checker.md
# trace_checker

Parametrised successor to the single-format CPU trace-line checker. It consumes a byte-serial ASCII trace stream, one character per clock, and recognises register-write lines `^T@PPPPPPPP: $R <= DDDDDDDD#` and memory-write lines `^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`. For each well-formed line it reports the format, an error code, the parsed fields, and running line/error statistics. It sits between the trace UART/byte source and the verification scoreboard.

## Interface
- `TIME_DIGITS`, default 4: maximum decimal digits in time field T (minimum 1).
- `REG_DIGITS`, default 2: maximum decimal digits in register field R (minimum 1).
- `NUM_REGS`, default 32: legal register indices are 0..NUM_REGS-1.
- `PC_LO`, default 32'h0000_3000: lowest legal PC.
- `PC_HI`, default 32'h0000_4FFF: highest legal PC.
- `ADDR_LO`, default 32'h0000_0000: lowest legal data address.
- `ADDR_HI`, default 32'h0000_2FFF: highest legal data address.
- `UPPER_HEX`, default 0: when 1, `A`-`F` are also accepted as hex digits.
- `CNT_W`, default 16: width of the statistics counters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `char` in 8: ASCII character, sampled on every rising `clk`.
- `freq` in 16: reference frequency used for the time check.
- `format_type` out 2: 0 = none, 1 = register line, 2 = memory line.
- `error_code` out 4: error flags (see Operation).
- `line_valid` out 1: one-cycle pulse when a line is accepted.
- `pc_out` out 32: parsed PC.
- `dest_out` out 32: register index (zero-extended) or memory address.
- `data_out` out 32: parsed data word.
- `line_cnt` out CNT_W: count of accepted lines.
- `err_cnt` out CNT_W: count of accepted lines with a non-zero `error_code`.

## Operation
- Grammar, in order:
  - `^`
  - 1..TIME_DIGITS decimal digits
  - `@`
  - exactly 8 hex digits
  - `:`
  - zero or more spaces
  - either `$` followed by 1..REG_DIGITS decimal digits, or `*` followed by exactly 8 hex digits
  - zero or more spaces
  - `<=`, with no gap between `<` and `=`
  - zero or more spaces
  - exactly 8 hex digits
  - `#`
- Hex digits are `0-9` and `a-f`, plus `A-F` when UPPER_HEX=1.
- States: IDLE, TIME, PC, COLON_SP, DEST_PFX, REG, ADDR, PRE_LT, EQ, PRE_DATA, DATA.
- Any character that does not fit the grammar discards the line and returns to IDLE.
- Restart rule: a `^` received in any state discards the current line and enters TIME with all accumulators cleared. This is new behaviour.
- Digit-count overflow in any field discards the line.
- T, R, P, A and D are accumulated as 32-bit values. T and R are decimal (x·10 + d); P, A and D are hex (x·16 + d).
- On `#` in DATA with exactly 8 data digits, the line is accepted. `error_code` bits are then set as follows:
  - bit0 (time): `(T & -T)` < `{1'b0, freq[15:1]}`, using 32-bit two's complement. T=0 therefore flags whenever freq ≥ 2.
  - bit1 (PC): P < PC_LO, or P > PC_HI, or `P[1:0]` ≠ 0.
  - bit2 (address), memory lines only: A < ADDR_LO, or A > ADDR_HI, or `A[1:0]` ≠ 0.
  - bit3 (register), register lines only: R ≥ NUM_REGS.
- `line_cnt` increments on every accepted line. `err_cnt` increments when `error_code` ≠ 0. Both counters saturate at all-ones.

## Timing
- Reset values:
  - `format_type`, `error_code`, `line_valid`, `pc_out`, `dest_out`, `data_out`, `line_cnt`, `err_cnt` all reset to 0.
  - The FSM resets to IDLE.
- Latency: the `#` is sampled at edge k. At edge k, the outputs `format_type`, `error_code` and `line_valid` become valid and hold for exactly one cycle. They return to 0 at edge k+1 unless another line is accepted at that edge.
- `pc_out`, `dest_out` and `data_out` update at edge k and hold until the next accepted line.
- Counters update at edge k.
- The cycle after `#` returns to IDLE, so a `^` in that cycle starts a new line (back-to-back lines, zero gap).
- `reset` asserted mid-line: the line is discarded and the counters clear. Reset takes priority over a coincident `#`.
- `freq` is sampled at the `#` edge only.

## Structure
- Package `trace_checker_pkg` holds:
  - the state enum
  - the error-bit index constants (ERR_TIME=0, ERR_PC=1, ERR_ADDR=2, ERR_REG=3)
  - the format codes (FMT_NONE, FMT_REG, FMT_MEM)
  - the ASCII constants
- Sub-module `char_classify`: combinational. Maps `char` and UPPER_HEX to `is_dec`, `is_hex` and a 4-bit value `nib`.
- Top level contains the FSM, accumulators, digit counter, checks and statistics.

## Test plan
- Reset defaults (UPPER_HEX=0), freq=2. Stream `^10@00003000: $5 <= 0000000a#` → `format_type`=1, `error_code`=0, `line_valid` pulse, `pc_out`=0x3000, `dest_out`=5, `data_out`=0xA, `line_cnt`=1.
- freq=2. Stream `^8@00003004:*00000010<=12345678#` (no spaces) → `format_type`=2, `error_code`=0, `dest_out`=0x10, `data_out`=0x12345678.
- freq=32. Stream `^12@00003002: $40 <= 00000000#` → `format_type`=1, `error_code`=4'b1011, `err_cnt`=1.
- Restart and address range. Stream `^12@^3@00003000: *00003000 <= 00000000#` with freq=2 → only the second line is accepted: `format_type`=2, `error_code`=4'b0100.
- Malformed lines produce no response:
  - `^1@3000: $1 <= 00000000#` (short PC)
  - `^12345@00003000: $1 <= 00000000#` (time field too long)
  - `^1@00003000: $1 < = 00000000#` (gap between `<` and `=`)
  - Each → `line_valid` stays 0 and the counters are unchanged.
- UPPER_HEX=1: `^4@0000300C: *0000ABCC <= FFFFFFFF#` → `pc_out`=0x300C, `error_code`=4'b0100. Separately, assert `reset` after the 5th character of a line → no output, counters 0, and the next clean line is accepted.
